// File: rtl/lsq_unit_if.sv
// Dispatch/execute/commit/memory-write handshake bundle for lsq_unit.
// slave = queue side, master = pipeline and memory side.
interface lsq_unit_if #(
   parameter int LSQ_SIZE = 8,
   parameter int TAG_W    = 4,
   parameter int DATA_W   = 32
);
   localparam int IDX_W = $clog2(LSQ_SIZE);

   logic              alloc_valid;
   logic              alloc_is_store;
   logic [TAG_W-1:0]  alloc_tag;
   logic              alloc_ready;
   logic [IDX_W-1:0]  alloc_id;

   logic              addr_valid;
   logic [IDX_W-1:0]  addr_id;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] st_data;

   logic              commit_valid;
   logic [TAG_W-1:0]  commit_tag;
   logic              flush;

   logic              mem_req_valid;
   logic [DATA_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_data;
   logic              mem_req_ack;

   modport slave (
      input  alloc_valid, alloc_is_store, alloc_tag,
      output alloc_ready, alloc_id,
      input  addr_valid, addr_id, addr, st_data,
      input  commit_valid, commit_tag, flush,
      output mem_req_valid, mem_req_addr, mem_req_data,
      input  mem_req_ack
   );

   modport master (
      output alloc_valid, alloc_is_store, alloc_tag,
      input  alloc_ready, alloc_id,
      output addr_valid, addr_id, addr, st_data,
      output commit_valid, commit_tag, flush,
      input  mem_req_valid, mem_req_addr, mem_req_data,
      output mem_req_ack
   );
endinterface

// File: rtl/lsq_unit.sv
// Circular load/store queue: alloc at tail, in-order commit at head; committed stores drain one at a time.
// Store commit at edge E raises mem_req_valid after E+1; write held until ack; alloc stalls on registered count full.
module lsq_unit #(
   parameter  int LSQ_SIZE = 8,
   parameter  int TAG_W    = 4,
   parameter  int DATA_W   = 32,
   localparam int IDX_W    = $clog2(LSQ_SIZE)
) (
   input  logic                clk,
   input  logic                reset,
   lsq_unit_if.slave           bus,
   output logic [IDX_W-1:0]    head,
   output logic [IDX_W-1:0]    tail,
   output logic [IDX_W:0]      count,
   output logic [LSQ_SIZE-1:0] entry_valid,
   output logic [LSQ_SIZE-1:0] entry_is_store
);

   localparam logic [IDX_W:0] FULL = (IDX_W+1)'(LSQ_SIZE);

   typedef struct packed {
      logic              valid;
      logic              is_store;
      logic [TAG_W-1:0]  tag;
      logic              addr_ready;
      logic              committed;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef enum logic {IDLE, WRITE} wr_state_t;

   entry_t     ent [LSQ_SIZE];
   entry_t     hd;
   wr_state_t  state, state_nxt;

   logic             head_cst;
   logic             alloc_fire;
   logic             commit_ok;
   logic             load_pop;
   logic             store_commit;
   logic             store_pop;
   logic             pop;
   logic             fill_ok;
   logic             keep;
   logic [IDX_W-1:0] head_nxt;

   assign hd       = ent[head];
   assign head_cst = hd.valid && hd.is_store && hd.committed;

   assign bus.alloc_ready = (count < FULL);
   assign bus.alloc_id    = tail;

   assign alloc_fire   = bus.alloc_valid && bus.alloc_ready && !bus.flush;
   // A committed head no longer accepts commits, so a retried tag cannot re-commit it.
   assign commit_ok    = !bus.flush && bus.commit_valid && (count != '0) && hd.valid &&
                         hd.addr_ready && !hd.committed && (bus.commit_tag == hd.tag);
   assign load_pop     = commit_ok && !hd.is_store;
   assign store_commit = commit_ok && hd.is_store;
   assign store_pop    = (state == WRITE) && bus.mem_req_ack;
   assign pop          = load_pop || store_pop;
   assign fill_ok      = !bus.flush && bus.addr_valid && ent[bus.addr_id].valid &&
                         !(pop && (bus.addr_id == head));
   assign keep         = head_cst && !store_pop;
   assign head_nxt     = head + IDX_W'(pop);

   assign bus.mem_req_valid = (state == WRITE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (head_cst) state_nxt = WRITE;
         WRITE:   if (bus.mem_req_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mem_req_addr <= '0;
         bus.mem_req_data <= '0;
      end else if (state == IDLE && head_cst) begin
         bus.mem_req_addr <= hd.addr;
         bus.mem_req_data <= hd.data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.flush) begin
         head  <= head_nxt;
         tail  <= head_nxt + IDX_W'(keep);
         count <= (IDX_W+1)'(keep);
      end else begin
         head  <= head_nxt;
         tail  <= tail + IDX_W'(alloc_fire);
         count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LSQ_SIZE; i++) ent[i] <= '0;
      end else begin
         for (int i = 0; i < LSQ_SIZE; i++) begin
            if (bus.flush) begin
               // Only a committed store at head survives; it is architecturally retired.
               if (!(keep && (IDX_W'(i) == head))) ent[i] <= '0;
            end else begin
               if (pop && (IDX_W'(i) == head)) begin
                  ent[i] <= '0;
               end else if (alloc_fire && (IDX_W'(i) == tail)) begin
                  ent[i].valid      <= 1'b1;
                  ent[i].is_store   <= bus.alloc_is_store;
                  ent[i].tag        <= bus.alloc_tag;
                  ent[i].addr_ready <= 1'b0;
                  ent[i].committed  <= 1'b0;
               end else if (fill_ok && (IDX_W'(i) == bus.addr_id)) begin
                  ent[i].addr       <= bus.addr;
                  ent[i].data       <= bus.st_data;
                  ent[i].addr_ready <= 1'b1;
               end
               if (store_commit && (IDX_W'(i) == head)) ent[i].committed <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      entry_valid    = '0;
      entry_is_store = '0;
      for (int i = 0; i < LSQ_SIZE; i++) begin
         entry_valid[i]    = ent[i].valid;
         entry_is_store[i] = ent[i].is_store;
      end
   end

endmodule

// File: tb/tb_lsq_unit.sv
// Directed plan plus randomized traffic, checked every cycle against a program-order queue model.
module tb_lsq_unit;
   localparam int N  = 8;
   localparam int TW = 4;
   localparam int DW = 32;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lsq_unit_if #(.LSQ_SIZE(N), .TAG_W(TW), .DATA_W(DW)) bus();

   logic [IW-1:0] head, tail;
   logic [IW:0]   count;
   logic [N-1:0]  entry_valid, entry_is_store;

   lsq_unit #(.LSQ_SIZE(N), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .head(head), .tail(tail), .count(count),
      .entry_valid(entry_valid), .entry_is_store(entry_is_store)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          is_store;
      bit [TW-1:0] tag;
      bit          addr_ready;
      bit          committed;
      bit [DW-1:0] addr;
      bit [DW-1:0] data;
   } ment_t;

   ment_t       q[$];
   int          m_head;
   bit          m_wr;
   bit [DW-1:0] m_waddr, m_wdata;

   function automatic void model_reset();
      q.delete();
      m_head  = 0;
      m_wr    = 0;
      m_waddr = '0;
      m_wdata = '0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_edge();
      int    sz = q.size();
      ment_t h;
      ment_t e;
      bit    pop_st, cok, pop_ld, keep;
      int    pos;
      h = '{default: 0};
      if (sz > 0) h = q[0];
      pop_st = m_wr && bus.mem_req_ack;
      cok    = !bus.flush && bus.commit_valid && sz > 0 && h.addr_ready &&
               !h.committed && (h.tag == bus.commit_tag);
      pop_ld = cok && !h.is_store;
      if (m_wr) begin
         if (bus.mem_req_ack) m_wr = 0;
      end else if (sz > 0 && h.committed) begin
         m_wr    = 1;
         m_waddr = h.addr;
         m_wdata = h.data;
      end
      if (bus.flush) begin
         keep = sz > 0 && h.committed && !pop_st;
         if (pop_st) m_head = (m_head + 1) % N;
         q.delete();
         if (keep) q.push_back(h);
      end else begin
         pos = (int'(bus.addr_id) - m_head + N) % N;
         if (bus.addr_valid && pos < sz && !(pos == 0 && (pop_st || pop_ld))) begin
            q[pos].addr       = bus.addr;
            q[pos].data       = bus.st_data;
            q[pos].addr_ready = 1;
         end
         if (cok && h.is_store) q[0].committed = 1;
         if (pop_st || pop_ld) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % N;
         end
         if (bus.alloc_valid && sz < N) begin
            e = '{default: 0};
            e.is_store = bus.alloc_is_store;
            e.tag      = bus.alloc_tag;
            q.push_back(e);
         end
      end
   endfunction

   task automatic compare();
      bit [N-1:0] ev, es;
      int         etail;
      ev = '0;
      es = '0;
      for (int i = 0; i < q.size(); i++) begin
         ev[(m_head + i) % N] = 1'b1;
         es[(m_head + i) % N] = q[i].is_store;
      end
      etail = (m_head + q.size()) % N;
      check("count",       64'(count),             64'(q.size()));
      check("head",        64'(head),              64'(m_head));
      check("tail",        64'(tail),              64'(etail));
      check("alloc_ready", 64'(bus.alloc_ready),   64'(q.size() < N));
      check("alloc_id",    64'(bus.alloc_id),      64'(etail));
      check("req_valid",   64'(bus.mem_req_valid), 64'(m_wr));
      check("req_addr",    64'(bus.mem_req_addr),  64'(m_waddr));
      check("req_data",    64'(bus.mem_req_data),  64'(m_wdata));
      check("entry_valid", 64'(entry_valid),       64'(ev));
      check("entry_store", 64'(entry_is_store),    64'(es));
   endtask

   task automatic idle_inputs();
      bus.alloc_valid    = 1'b0;
      bus.alloc_is_store = 1'b0;
      bus.alloc_tag      = '0;
      bus.addr_valid     = 1'b0;
      bus.addr_id        = '0;
      bus.addr           = '0;
      bus.st_data        = '0;
      bus.commit_valid   = 1'b0;
      bus.commit_tag     = '0;
      bus.flush          = 1'b0;
      bus.mem_req_ack    = 1'b0;
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      compare();
   endtask

   task automatic alloc1(input bit st, input int tag);
      bus.alloc_valid = 1'b1; bus.alloc_is_store = st; bus.alloc_tag = TW'(tag);
      cyc();
      bus.alloc_valid = 1'b0;
   endtask

   task automatic fill1(input int id, input int a, input int d);
      bus.addr_valid = 1'b1; bus.addr_id = IW'(id); bus.addr = DW'(a); bus.st_data = DW'(d);
      cyc();
      bus.addr_valid = 1'b0;
   endtask

   task automatic commit1(input int tag);
      bus.commit_valid = 1'b1; bus.commit_tag = TW'(tag);
      cyc();
      bus.commit_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      model_reset();
      #1;
      check("rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
      do_reset();
      check("rst_count", 64'(count), 64'(0));
      check("rst_ev",    64'(entry_valid), 64'(0));

      // load + store, fill, drain the store
      alloc1(0, 3);
      alloc1(1, 4);
      fill1(0, 'h100, 0);
      fill1(1, 'h104, 'hAB);
      check("p1_tail",  64'(tail), 64'(2));
      check("p1_count", 64'(count), 64'(2));
      check("p1_store", 64'(entry_is_store), 64'(8'b0000_0010));
      commit1(3);
      check("p2_head", 64'(head), 64'(1));
      commit1(4);
      check("p2_lat_lo", 64'(bus.mem_req_valid), 64'(0));
      cyc();
      check("p2_req",  64'(bus.mem_req_valid), 64'(1));
      check("p2_addr", 64'(bus.mem_req_addr), 64'('h104));
      check("p2_data", 64'(bus.mem_req_data), 64'('hAB));
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("p2_hold_v", 64'(bus.mem_req_valid), 64'(1));
         check("p2_hold_a", 64'(bus.mem_req_addr), 64'('h104));
      end
      bus.mem_req_ack = 1'b1;
      cyc();
      bus.mem_req_ack = 1'b0;
      check("p2_ack_head",  64'(head), 64'(2));
      check("p2_ack_count", 64'(count), 64'(0));
      check("p2_ack_req",   64'(bus.mem_req_valid), 64'(0));

      // full queue, commit with same-cycle alloc
      do_reset();
      for (int k = 0; k <= N; k++) begin
         bus.alloc_valid = (k < N); bus.alloc_is_store = 1'b0; bus.alloc_tag = TW'(k);
         bus.addr_valid = (k > 0); bus.addr_id = IW'(k - 1); bus.addr = DW'('h200 + 4*k);
         cyc();
      end
      idle_inputs();
      check("p3_full_rdy", 64'(bus.alloc_ready), 64'(0));
      check("p3_full_cnt", 64'(count), 64'(8));
      bus.alloc_valid = 1'b1; bus.alloc_tag = TW'(8);
      bus.commit_valid = 1'b1; bus.commit_tag = TW'(0);
      cyc();
      bus.commit_valid = 1'b0;
      check("p3_noalloc_cnt", 64'(count), 64'(7));
      check("p3_alloc_id",    64'(bus.alloc_id), 64'(0));
      cyc();
      bus.alloc_valid = 1'b0;
      check("p3_wrap_tail", 64'(tail), 64'(1));
      check("p3_wrap_cnt",  64'(count), 64'(8));

      // ignored commits
      commit1(9);
      check("p4_badtag_head", 64'(head), 64'(1));
      check("p4_badtag_cnt",  64'(count), 64'(8));
      do_reset();
      alloc1(1, 5);
      commit1(5);
      cyc();
      check("p4_noaddr_head", 64'(head), 64'(0));
      check("p4_noaddr_cnt",  64'(count), 64'(1));
      check("p4_noaddr_req",  64'(bus.mem_req_valid), 64'(0));

      // flush with a store in flight
      fill1(0, 'h300, 'h55);
      commit1(5);
      alloc1(0, 6);
      check("p5_req", 64'(bus.mem_req_valid), 64'(1));
      alloc1(0, 7);
      alloc1(0, 8);
      check("p5_pre_cnt", 64'(count), 64'(4));
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      check("p5_fl_cnt",  64'(count), 64'(1));
      check("p5_fl_tail", 64'(tail), 64'(1));
      check("p5_fl_req",  64'(bus.mem_req_valid), 64'(1));
      check("p5_fl_addr", 64'(bus.mem_req_addr), 64'('h300));
      bus.mem_req_ack = 1'b1;
      cyc();
      bus.mem_req_ack = 1'b0;
      check("p5_done_cnt", 64'(count), 64'(0));

      // async reset during a write
      alloc1(1, 2);
      fill1(1, 'h400, 'h77);
      commit1(2);
      cyc();
      check("p6_req", 64'(bus.mem_req_valid), 64'(1));
      #3;
      reset = 1'b1;
      #1;
      check("p6_rst_req",  64'(bus.mem_req_valid), 64'(0));
      check("p6_rst_head", 64'(head), 64'(0));
      check("p6_rst_tail", 64'(tail), 64'(0));
      check("p6_rst_cnt",  64'(count), 64'(0));
      check("p6_rst_ev",   64'(entry_valid), 64'(0));
      do_reset();

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         bus.alloc_valid    = 1'($urandom % 2);
         bus.alloc_is_store = 1'($urandom % 2);
         bus.alloc_tag      = TW'($urandom);
         bus.addr_valid     = ($urandom % 3) != 0;
         bus.addr_id        = IW'((m_head + int'($urandom_range(0, q.size()))) % N);
         bus.addr           = DW'($urandom);
         bus.st_data        = DW'($urandom);
         bus.commit_valid   = 1'($urandom % 2);
         if (q.size() > 0 && ($urandom % 4) != 0) bus.commit_tag = q[0].tag;
         else                                     bus.commit_tag = TW'($urandom);
         bus.flush          = ($urandom % 50) == 0;
         bus.mem_req_ack    = ($urandom % 3) == 0;
         cyc();
      end
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
